// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: packet-atomic round-robin arbiter feeding the SPI slave's
// host-bound byte stream. Each packet is optionally prefixed by a tag byte
// {4'hA, source id} so the host can demultiplex READ_BYTES traffic.
//
// Ports:
//   clk, reset_n          - system clock, async active-low reset
//   req_data/vld/last     - per-requester byte, valid, end-of-packet (packed lanes)
//   req_rdy               - per-requester ready (one-hot or zero)
//   out_data/vld, out_rdy - stream towards SPI slave write_data/vld/rdy
//   grant_id              - current or last granted requester
//   busy                  - a packet (tag or data) is in flight
//   err_overrun           - sticky: a packet was force-released at MAX_LEN beats
module spi_tx_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TAG_EN  = 1,
  parameter int unsigned MAX_LEN = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  input  logic [NREQ-1:0]           req_vld,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           req_rdy,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic                      err_overrun
);

  localparam int unsigned GW = $clog2(NREQ);
  localparam int unsigned LW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TAG  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [LW-1:0]   len_q, len_d;
  logic            err_q, err_d;
  logic            busy_q;

  logic [WIDTH-1:0] lane_data [NREQ];
  logic [GW-1:0]    win;
  logic             any_vld;
  logic             data_beat;
  logic [GW-1:0]    next_ptr;

  // Unpack the flat request bus into per-lane bytes
  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      lane_data[i] = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Round-robin pick: first valid lane at ptr, ptr+1, ... (mod NREQ).
  // Scanning from the far end lets the closest lane overwrite the result.
  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    any_vld = |req_vld;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % int'(NREQ);
      if (req_vld[GW'(idx)]) begin
        win = GW'(idx);
      end
    end
  end

  assign data_beat = req_vld[grant_q] & out_rdy;
  assign next_ptr  = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      len_q   <= len_d;
      err_q   <= err_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    len_d   = len_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_vld) begin
          grant_d = win;
          len_d   = '0;
          state_d = (TAG_EN != 0) ? ST_TAG : ST_DATA;
        end
      end
      ST_TAG: begin
        if (out_rdy) begin
          len_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (data_beat) begin
          len_d = len_q + LW'(1);
          if (req_last[grant_q]) begin
            ptr_d   = next_ptr;
            state_d = ST_IDLE;
          end else if (len_q == LW'(MAX_LEN - 1)) begin
            // Forced release; the remainder becomes a fresh packet later
            err_d   = 1'b1;
            ptr_d   = next_ptr;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stream outputs: tag is driven from registers, data is a pass-through
  always_comb begin
    out_data = '0;
    out_vld  = 1'b0;
    req_rdy  = '0;
    unique case (state_q)
      ST_TAG: begin
        out_data = WIDTH'({4'hA, 4'(grant_q)});
        out_vld  = 1'b1;
      end
      ST_DATA: begin
        out_data         = lane_data[grant_q];
        out_vld          = req_vld[grant_q];
        req_rdy[grant_q] = out_rdy;
      end
      default: ;
    endcase
  end

  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Self-checking bench for spi_tx_arbiter: directed scenarios plus randomized
// traffic, compared cycle by cycle against a packet-level reference model.
module tb_spi_tx_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int GW   = 2;
  localparam int MAXL = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_vld;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_rdy;
  logic [W-1:0]      out_data;
  logic              out_vld;
  logic              out_rdy;
  logic [GW-1:0]     grant_id;
  logic              busy;
  logic              err_overrun;

  always #5 clk = ~clk;

  spi_tx_arbiter #(
    .NREQ(NREQ), .WIDTH(W), .TAG_EN(1), .MAX_LEN(MAXL)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_data(req_data), .req_vld(req_vld), .req_last(req_last), .req_rdy(req_rdy),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .grant_id(grant_id), .busy(busy), .err_overrun(err_overrun)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Per-requester pending bytes: {last, data}
  logic [8:0] lq [NREQ][$];
  int gap_pct  = 0;
  bit rdy_rand = 0;

  // Reference model: who owns the stream, whether its tag is still owed,
  // how many data bytes it has sent, and where the next search starts.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_grant = 0;
  int m_cnt   = 0;
  bit m_tag   = 0;
  bit m_err   = 0;

  logic [7:0] obs [$];
  int         beats_seen = 0;
  bit         hold_prev  = 0;
  logic [7:0] hold_data  = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_byte(input int lane, input logic [7:0] d, input bit last);
    lq[lane].push_back({last, d});
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NREQ; i++) if (lq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (lq[i].size() != 0) begin
        req_data[i*W +: W] = lq[i][0][7:0];
        req_last[i]        = lq[i][0][8];
        req_vld[i]         = (gap_pct == 0) || (int'($urandom_range(99)) >= gap_pct);
      end else begin
        req_data[i*W +: W] = '0;
        req_last[i]        = 1'b0;
        req_vld[i]         = 1'b0;
      end
    end
    out_rdy = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
  endtask

  // One clock: check at the negedge, advance model, drive after posedge.
  task automatic cycle();
    logic [NREQ-1:0] e_rdy;
    logic            e_vld;
    logic [7:0]      e_data;
    logic            e_busy;
    logic            e_last;
    bit              pop [NREQ];
    e_rdy = '0; e_vld = 1'b0; e_data = '0; e_busy = 1'b0; e_last = 1'b0;
    if (m_owner >= 0) begin
      e_busy = 1'b1;
      if (m_tag) begin
        e_vld  = 1'b1;
        e_data = 8'hA0 | 8'(m_owner);
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          if (i == m_owner) begin
            e_vld    = req_vld[i];
            e_data   = req_data[i*W +: W];
            e_last   = req_last[i];
            e_rdy[i] = out_rdy;
          end
        end
      end
    end
    chk("out_vld", out_vld, e_vld);
    if (e_vld) chk("out_data", out_data, e_data);
    chk("req_rdy", req_rdy, e_rdy);
    chk("busy", busy, e_busy);
    chk("grant_id", grant_id, m_grant);
    chk("err_overrun", err_overrun, m_err);
    if (hold_prev && out_vld) chk("hold", out_data, hold_data);
    hold_prev = out_vld && !out_rdy;
    hold_data = out_data;
    if (out_vld && out_rdy) begin
      obs.push_back(out_data);
      beats_seen++;
    end
    for (int i = 0; i < NREQ; i++) pop[i] = req_vld[i] && e_rdy[i];

    if (m_owner < 0) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (req_vld[GW'((m_ptr + k) % NREQ)]) m_owner = (m_ptr + k) % NREQ;
      end
      if (m_owner >= 0) begin
        m_grant = m_owner;
        m_tag   = 1'b1;
        m_cnt   = 0;
      end
    end else if (m_tag) begin
      if (out_rdy) m_tag = 1'b0;
    end else if (e_vld && out_rdy) begin
      m_cnt++;
      if (e_last || m_cnt == MAXL) begin
        if (!e_last) m_err = 1'b1;
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
      end
    end

    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (pop[i]) void'(lq[i].pop_front());
    drive();
    @(negedge clk);
  endtask

  task automatic run_idle(input int budget);
    int c;
    c = 0;
    while (!(all_empty() && m_owner < 0) && c < budget) begin
      cycle();
      c++;
    end
    chk("drained", (all_empty() && m_owner < 0), 1);
    cycle();
    cycle();
  endtask

  task automatic chk_stream(input string tag, input logic [7:0] exp [$]);
    chk({tag, "_len"}, obs.size(), exp.size());
    foreach (exp[i]) chk(tag, (i < obs.size()) ? 32'(obs[i]) : 32'hDEAD, exp[i]);
  endtask

  initial begin
    logic [7:0] exp [$];
    int c;
    int exp_beats;
    req_data = '0; req_vld = '0; req_last = '0; out_rdy = 1'b1;
    reset_n  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_err", err_overrun, 0);
    reset_n = 1'b1;
    @(posedge clk); #1; drive(); @(negedge clk);

    // Fairness: every lane has back-to-back single-byte packets
    obs.delete();
    for (int r = 0; r < NREQ; r++) begin
      push_byte(r, 8'(8'h40 + r), 1'b1);
      push_byte(r, 8'(8'h40 + r), 1'b1);
    end
    run_idle(200);
    exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    for (int i = 0; i < 5; i++)
      chk("fair_tag", (2*i < obs.size()) ? 32'(obs[2*i]) : 32'hDEAD, exp[i]);

    // Single source, lane 2, three bytes
    obs.delete();
    push_byte(2, 8'h11, 1'b0); push_byte(2, 8'h22, 1'b0); push_byte(2, 8'h33, 1'b1);
    run_idle(100);
    chk_stream("single", '{8'hA2, 8'h11, 8'h22, 8'h33});

    // Atomicity: lane 0 arrives while lane 1 is mid-packet
    obs.delete();
    for (int i = 0; i < 4; i++) push_byte(1, 8'(8'h50 + i), i == 3);
    repeat (3) cycle();
    push_byte(0, 8'h60, 1'b1);
    run_idle(100);
    chk_stream("atomic", '{8'hA1, 8'h50, 8'h51, 8'h52, 8'h53, 8'hA0, 8'h60});

    // Overrun: lane 3 sends MAXL+2 bytes in one packet
    obs.delete();
    for (int i = 0; i < MAXL + 2; i++) push_byte(3, 8'(8'h70 + i), i == MAXL + 1);
    run_idle(200);
    exp.delete();
    exp.push_back(8'hA3);
    for (int i = 0; i < MAXL; i++) exp.push_back(8'(8'h70 + i));
    exp.push_back(8'hA3);
    exp.push_back(8'(8'h70 + MAXL));
    exp.push_back(8'(8'h70 + MAXL + 1));
    chk_stream("overrun", exp);
    chk("overrun_flag", err_overrun, 1);

    // Backpressure: random out_rdy over a 5-byte packet
    obs.delete();
    rdy_rand = 1;
    for (int i = 0; i < 5; i++) push_byte(0, 8'(8'h80 + i), i == 4);
    run_idle(400);
    rdy_rand = 0;
    chk_stream("bp", '{8'hA0, 8'h80, 8'h81, 8'h82, 8'h83, 8'h84});

    // Reset asserted in the middle of a data phase
    for (int i = 0; i < 6; i++) push_byte(1, 8'(8'h90 + i), i == 5);
    c = 0;
    while (!(m_owner == 1 && !m_tag && m_cnt >= 1) && c < 50) begin
      cycle();
      c++;
    end
    chk("reached_data", (m_owner == 1 && !m_tag && m_cnt >= 1), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_vld", out_vld, 0);
    chk("mid_rst_rdy", req_rdy, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_grant", grant_id, 0);
    for (int i = 0; i < NREQ; i++) lq[i].delete();
    m_owner = -1; m_ptr = 0; m_grant = 0; m_cnt = 0; m_tag = 0; m_err = 0;
    hold_prev = 0;
    @(posedge clk); #1; drive(); @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1; drive(); @(negedge clk);
    obs.delete();
    push_byte(2, 8'hB2, 1'b1);
    push_byte(0, 8'hB0, 1'b1);
    run_idle(100);
    chk_stream("post_rst", '{8'hA0, 8'hB0, 8'hA2, 8'hB2});

    // Randomized traffic with vld gaps and backpressure
    gap_pct    = 20;
    rdy_rand   = 1;
    beats_seen = 0;
    exp_beats  = 0;
    for (int p = 0; p < 120; p++) begin
      int lane;
      int len;
      lane = int'($urandom_range(NREQ - 1));
      len  = int'($urandom_range(12, 1));
      for (int i = 0; i < len; i++) push_byte(lane, 8'($urandom), i == len - 1);
      exp_beats += len + (len + MAXL - 1) / MAXL;
      repeat ($urandom_range(6)) cycle();
    end
    run_idle(20000);
    chk("rand_beats", beats_seen, exp_beats);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_tx_arbiter.md
# spi_tx_arbiter

Packet-atomic round-robin arbiter that shares the SPI slave's host-bound byte stream (`write_data`/`write_vld`/`write_rdy`) between several on-chip requesters, such as the core event output, the status responder and the config readback unit. Each packet may optionally be prefixed with a tag byte identifying its source, so the host can demultiplex the bytes it pulls with READ_BYTES. The block sits between the requesters and the SPI slave's read FIFO input and never interleaves bytes from two packets.

## Interface
- `NREQ`, default 4: number of requesters, legal range 2..16.
- `WIDTH`, default 8: byte width; must match the SPI slave.
- `TAG_EN`, default 1: when 1, a tag byte is emitted before each packet.
- `MAX_LEN`, default 64: maximum data beats per packet before a forced release.
- `clk` input, 1 bit: single system clock; all logic on its rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `req_data` input, NREQ*WIDTH bits: requester i's byte at bits [i*WIDTH +: WIDTH].
- `req_vld` input, NREQ bits: per-requester data valid.
- `req_last` input, NREQ bits: marks the final byte of a packet; qualified by vld.
- `req_rdy` output, NREQ bits: per-requester ready; at most one bit high at any time.
- `out_data` output, WIDTH bits: to SPI slave `write_data`.
- `out_vld` output, 1 bit: to SPI slave `write_vld`.
- `out_rdy` input, 1 bit: from SPI slave `write_rdy`.
- `grant_id` output, $clog2(NREQ) bits: current or last granted requester.
- `busy` output, 1 bit: high in the TAG and DATA states.
- `err_overrun` output, 1 bit: sticky; set on a MAX_LEN forced release and cleared only by reset.

## Operation
- FSM states are IDLE, TAG and DATA. A beat is a cycle with vld & rdy.
- IDLE:
  - `out_vld`=0 and `req_rdy`=0.
  - If any `req_vld` is high, grant the first requester with vld set, searching ptr, ptr+1, … modulo NREQ.
  - Register the winner into `grant_id`. Go to TAG if TAG_EN, else DATA.
- TAG:
  - `out_data` = {4'hA, grant_id zero-extended to 4 bits}; `out_vld`=1.
  - `out_data` is held stable until `out_rdy`; on the beat, go to DATA.
  - `req_rdy` stays 0 in this state.
- DATA:
  - Combinational pass-through: `out_data`=req_data[g], `out_vld`=req_vld[g], `req_rdy[g]`=out_rdy, where g=grant_id. All other `req_rdy` bits are 0.
  - A beat count `len` (width $clog2(MAX_LEN+1)) increments on each beat and is cleared on entry to TAG/DATA.
  - On a beat with req_last[g]: ptr ← (g+1) mod NREQ, go to IDLE.
  - On a beat where len reaches MAX_LEN without last: set `err_overrun`, ptr ← (g+1) mod NREQ, go to IDLE. The requester's remaining bytes form a new packet in a later grant.
- A granted requester that drops `req_vld` mid-packet keeps the grant indefinitely; there is no timeout.
- Requesters whose vld rises while another packet is in flight wait; vld state in non-granted lanes is ignored.

## Timing
- Reset values (async assert, sync deassert by the integrating reset synchronizer):
  - state=IDLE, ptr=0, grant_id=0, len=0, err_overrun=0.
  - out_vld=0, req_rdy=0, busy=0, out_data=0.
- Grant latency: a req_vld first seen in IDLE at cycle n puts `out_vld` high at cycle n+1 (tag, or first data byte if TAG_EN=0).
- There is exactly one IDLE bubble cycle between consecutive packets, even when requests are back to back.
- With `out_rdy` held high, a packet of L data bytes occupies L+1 (TAG_EN=1) or L (TAG_EN=0) consecutive output cycles.
- `out_rdy` low stalls every state with no loss; `out_data` and `out_vld` are held.
- A single-byte packet (last on the first data beat) is legal: after the tag beat, one data beat, then IDLE.
- Pointer wrap: after granting NREQ-1, the search starts at 0.
- If reset_n asserts mid-packet, the FSM returns to IDLE immediately. Bytes already accepted by the SPI slave are not recalled; the partial packet is the host's responsibility.

## Test plan
- Single source, TAG_EN=1: requester 2 sends 3 bytes {0x11,0x22,0x33 last} with out_rdy=1 -> output is 0xA2,0x11,0x22,0x33 on consecutive cycles, one cycle after vld rises.
- Fairness: all 4 requesters continuously send 1-byte packets -> tags appear in order 0xA0,0xA1,0xA2,0xA3,0xA0; an IDLE bubble separates each packet.
- Backpressure: toggle out_rdy randomly during a 5-byte packet -> exactly 6 output beats in order, and out_data stays stable while out_vld=1 and out_rdy=0.
- Atomicity: requester 1 is mid-packet and requester 0 raises vld -> req_rdy[0] stays 0 until requester 1's last beat; requester 0's tag follows after one idle cycle.
- Overrun, MAX_LEN=4: requester 3 sends 6 bytes with last on byte 6 -> forced release after 4 data beats and err_overrun=1. Requester 3 is granted again later (ptr wrap) and its remaining 2 bytes are emitted under tag 0xA3.
- Reset mid-packet: assert reset_n low during DATA -> out_vld=0, req_rdy=0, busy=0 and grant_id=0 in the same cycle; after release, a new request on requester 0 is granted first.
